// File: rtl/memory_arbiter_pkg.sv
// Shared definitions for the cache-to-memory arbiter: default sizes, FSM and
// client encodings, and the round-robin pick used when both caches request.
package memory_arbiter_pkg;

  localparam int MEM_LATENCY_DEFAULT     = 5;
  localparam int MEM_DEPTH_LINES_DEFAULT = 4096;
  localparam int ADDRESS_WIDTH_DEFAULT   = 32;
  localparam int CACHE_LINE_SIZE_DEFAULT = 128;
  localparam int LINE_OFFSET_BITS        = 4;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANTED = 2'd1,
    ARB_BUSY    = 2'd2
  } arb_state_e;

  typedef enum logic {
    CLIENT_I = 1'b0,
    CLIENT_D = 1'b1
  } client_e;

  // With both caches requesting, the one that did not own the bus last wins.
  function automatic client_e pick_client(input logic i_req, input logic d_req,
                                          input client_e last);
    if (i_req && d_req) begin
      return (last == CLIENT_I) ? CLIENT_D : CLIENT_I;
    end else if (d_req) begin
      return CLIENT_D;
    end else begin
      return CLIENT_I;
    end
  endfunction

endpackage

// File: rtl/memory_arbiter_line_memory.sv
// Single-port line-wide backing store. Read data is registered and holds its
// value until the next read enable; contents are never cleared.
module line_memory #(
  parameter int WIDTH  = 128,
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    if (re) begin
      rd_data_q <= mem_q[addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/memory_arbiter.sv
// Responder side of the I-cache / D-cache memory handshake: grants one client
// at a time, runs fixed-latency line reads and writebacks against line_memory.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY     = MEM_LATENCY_DEFAULT,
  parameter int MEM_DEPTH_LINES = MEM_DEPTH_LINES_DEFAULT,
  parameter int ADDRESS_WIDTH   = ADDRESS_WIDTH_DEFAULT,
  parameter int CACHE_LINE_SIZE = CACHE_LINE_SIZE_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,

  input  logic                       i_mem_op_init,
  input  logic                       i_start_access,
  input  logic                       i_mem_op_done,
  input  logic [ADDRESS_WIDTH-1:0]   i_mem_address,
  output logic                       i_allow_op,
  output logic                       i_mem_data_ready,
  output logic [CACHE_LINE_SIZE-1:0] i_mem_data_out,

  input  logic                       d_mem_op_init,
  input  logic                       d_start_access,
  input  logic                       d_mem_op_done,
  input  logic                       d_mem_op,
  input  logic [ADDRESS_WIDTH-1:0]   d_mem_address,
  input  logic [CACHE_LINE_SIZE-1:0] d_mem_data_in,
  output logic                       d_allow_op,
  output logic                       d_mem_data_ready,
  output logic [CACHE_LINE_SIZE-1:0] d_mem_data_out
);

  localparam int IDX_W = $clog2(MEM_DEPTH_LINES);
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  arb_state_e                 state_q, state_d;
  client_e                    owner_q, owner_d;
  client_e                    last_grant_q, last_grant_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic                       op_q, op_d;
  logic [CACHE_LINE_SIZE-1:0] wdata_q, wdata_d;
  logic                       i_allow_q, i_allow_d;
  logic                       d_allow_q, d_allow_d;
  logic                       i_ready_q, i_ready_d;
  logic                       d_ready_q, d_ready_d;
  logic                       i_fresh_q, i_fresh_d;
  logic                       d_fresh_q, d_fresh_d;
  logic [CACHE_LINE_SIZE-1:0] i_hold_q, i_hold_d;
  logic [CACHE_LINE_SIZE-1:0] d_hold_q, d_hold_d;

  logic                       own_init, own_start, own_done;
  logic [IDX_W-1:0]           i_idx, d_idx;
  logic                       mem_we, mem_re;
  logic [CACHE_LINE_SIZE-1:0] rd_data;
  logic                       unused_addr_bits;

  // Line index is the address above the byte offset, wrapped to the store depth.
  assign i_idx = i_mem_address[LINE_OFFSET_BITS +: IDX_W];
  assign d_idx = d_mem_address[LINE_OFFSET_BITS +: IDX_W];
  assign unused_addr_bits = ^{i_mem_address, d_mem_address};

  assign own_init  = (owner_q == CLIENT_D) ? d_mem_op_init  : i_mem_op_init;
  assign own_start = (owner_q == CLIENT_D) ? d_start_access : i_start_access;
  assign own_done  = (owner_q == CLIENT_D) ? d_mem_op_done  : i_mem_op_done;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    op_d         = op_q;
    wdata_d      = wdata_q;
    i_allow_d    = i_allow_q;
    d_allow_d    = d_allow_q;
    i_ready_d    = 1'b0;
    d_ready_d    = 1'b0;
    i_fresh_d    = 1'b0;
    d_fresh_d    = 1'b0;
    i_hold_d     = i_fresh_q ? rd_data : i_hold_q;
    d_hold_d     = d_fresh_q ? rd_data : d_hold_q;
    mem_we       = 1'b0;
    mem_re       = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (i_mem_op_init || d_mem_op_init) begin
          owner_d   = pick_client(i_mem_op_init, d_mem_op_init, last_grant_q);
          state_d   = ARB_GRANTED;
          i_allow_d = (owner_d == CLIENT_I);
          d_allow_d = (owner_d == CLIENT_D);
        end
      end
      ARB_GRANTED: begin
        // Release takes priority over a same-cycle start_access.
        if (own_done || !own_init) begin
          state_d      = ARB_IDLE;
          last_grant_d = owner_q;
          i_allow_d    = 1'b0;
          d_allow_d    = 1'b0;
        end else if (own_start) begin
          state_d = ARB_BUSY;
          cnt_d   = CNT_LOAD;
          idx_d   = (owner_q == CLIENT_D) ? d_idx : i_idx;
          op_d    = (owner_q == CLIENT_D) && d_mem_op;
          wdata_d = d_mem_data_in;
        end
      end
      ARB_BUSY: begin
        if (cnt_q == '0) begin
          state_d   = ARB_GRANTED;
          mem_we    = op_q && !reset;
          mem_re    = !op_q && !reset;
          i_ready_d = (owner_q == CLIENT_I);
          d_ready_d = (owner_q == CLIENT_D);
          i_fresh_d = !op_q && (owner_q == CLIENT_I);
          d_fresh_d = !op_q && (owner_q == CLIENT_D);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      owner_q      <= CLIENT_I;
      last_grant_q <= CLIENT_I;
      cnt_q        <= '0;
      idx_q        <= '0;
      op_q         <= 1'b0;
      wdata_q      <= '0;
      i_allow_q    <= 1'b0;
      d_allow_q    <= 1'b0;
      i_ready_q    <= 1'b0;
      d_ready_q    <= 1'b0;
      i_fresh_q    <= 1'b0;
      d_fresh_q    <= 1'b0;
      i_hold_q     <= '0;
      d_hold_q     <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      op_q         <= op_d;
      wdata_q      <= wdata_d;
      i_allow_q    <= i_allow_d;
      d_allow_q    <= d_allow_d;
      i_ready_q    <= i_ready_d;
      d_ready_q    <= d_ready_d;
      i_fresh_q    <= i_fresh_d;
      d_fresh_q    <= d_fresh_d;
      i_hold_q     <= i_hold_d;
      d_hold_q     <= d_hold_d;
    end
  end

  line_memory #(
    .WIDTH  (CACHE_LINE_SIZE),
    .DEPTH  (MEM_DEPTH_LINES),
    .ADDR_W (IDX_W)
  ) u_line_memory (
    .clk     (clk),
    .we      (mem_we),
    .re      (mem_re),
    .addr    (idx_q),
    .wdata   (wdata_q),
    .rd_data (rd_data)
  );

  assign i_allow_op       = i_allow_q;
  assign d_allow_op       = d_allow_q;
  assign i_mem_data_ready = i_ready_q;
  assign d_mem_data_ready = d_ready_q;
  // The freshly registered RAM word is shown in the ready cycle, then held.
  assign i_mem_data_out   = i_fresh_q ? rd_data : i_hold_q;
  assign d_mem_data_out   = d_fresh_q ? rd_data : d_hold_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: grant, latency, read/write, round-robin,
// release corner cases, reset abort and index wrap.
module tb_memory_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_mem_op_init, i_start_access, i_mem_op_done;
  logic [31:0]  i_mem_address;
  logic         i_allow_op, i_mem_data_ready;
  logic [127:0] i_mem_data_out;
  logic         d_mem_op_init, d_start_access, d_mem_op_done, d_mem_op;
  logic [31:0]  d_mem_address;
  logic [127:0] d_mem_data_in;
  logic         d_allow_op, d_mem_data_ready;
  logic [127:0] d_mem_data_out;

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] PRE = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] AAA = 128'hAAAAAAAAAAAAAAAA5555555555555555;
  localparam logic [127:0] OLD = 128'hDEADBEEF00000000CAFEF00D11111111;
  localparam logic [127:0] NEW = 128'h0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F;
  localparam logic [127:0] WRP = 128'h13579BDF2468ACE013579BDF2468ACE0;

  always #5 clk = ~clk;

  memory_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .i_mem_op_init    (i_mem_op_init),
    .i_start_access   (i_start_access),
    .i_mem_op_done    (i_mem_op_done),
    .i_mem_address    (i_mem_address),
    .i_allow_op       (i_allow_op),
    .i_mem_data_ready (i_mem_data_ready),
    .i_mem_data_out   (i_mem_data_out),
    .d_mem_op_init    (d_mem_op_init),
    .d_start_access   (d_start_access),
    .d_mem_op_done    (d_mem_op_done),
    .d_mem_op         (d_mem_op),
    .d_mem_address    (d_mem_address),
    .d_mem_data_in    (d_mem_data_in),
    .d_allow_op       (d_allow_op),
    .d_mem_data_ready (d_mem_data_ready),
    .d_mem_data_out   (d_mem_data_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic d_access(input string tag, input logic op, input logic [31:0] addr,
                          input logic [127:0] wd, output logic [127:0] rd);
    int lat;
    d_mem_op       = op;
    d_mem_address  = addr;
    d_mem_data_in  = wd;
    d_start_access = 1'b1;
    tick();
    d_start_access = 1'b0;
    lat = 0;
    while (d_mem_data_ready !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, " latency"}, 128'(lat), 128'd5);
    chk({tag, " i_ready_quiet"}, 128'(i_mem_data_ready), 128'd0);
    chk({tag, " d_allow_held"}, 128'(d_allow_op), 128'd1);
    rd = d_mem_data_out;
    $display("d_access %s op=%0d addr=%h data=%h lat=%0d", tag, op, addr, rd, lat);
    tick();
    chk({tag, " ready_pulse"}, 128'(d_mem_data_ready), 128'd0);
  endtask

  task automatic i_access(input string tag, input logic [31:0] addr, output logic [127:0] rd);
    int lat;
    i_mem_address  = addr;
    i_start_access = 1'b1;
    tick();
    i_start_access = 1'b0;
    lat = 0;
    while (i_mem_data_ready !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, " latency"}, 128'(lat), 128'd5);
    chk({tag, " d_ready_quiet"}, 128'(d_mem_data_ready), 128'd0);
    rd = i_mem_data_out;
    $display("i_access %s addr=%h data=%h lat=%0d", tag, addr, rd, lat);
    tick();
    chk({tag, " ready_pulse"}, 128'(i_mem_data_ready), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [127:0] rd;
    int           lat;
    int           rcount;

    reset = 1'b1;
    i_mem_op_init = 0; i_start_access = 0; i_mem_op_done = 0; i_mem_address = '0;
    d_mem_op_init = 0; d_start_access = 0; d_mem_op_done = 0; d_mem_op = 0;
    d_mem_address = '0; d_mem_data_in = '0;
    repeat (3) tick();
    chk("rst i_allow", 128'(i_allow_op), 128'd0);
    chk("rst d_allow", 128'(d_allow_op), 128'd0);
    chk("rst i_ready", 128'(i_mem_data_ready), 128'd0);
    chk("rst d_ready", 128'(d_mem_data_ready), 128'd0);
    chk("rst i_data", i_mem_data_out, 128'd0);
    chk("rst d_data", d_mem_data_out, 128'd0);
    reset = 1'b0;

    // Initialisation: grant, preload line 0x10, read it back.
    d_mem_op_init = 1'b1;
    tick();
    chk("init d_allow", 128'(d_allow_op), 128'd1);
    chk("init i_allow", 128'(i_allow_op), 128'd0);
    d_access("preload", 1'b1, 32'h0000_0100, PRE, rd);
    d_access("read0x100", 1'b0, 32'h0000_0100, '0, rd);
    chk("read0x100 data", rd, PRE);
    chk("init i_data", i_mem_data_out, 128'd0);
    chk("init i_allow2", 128'(i_allow_op), 128'd0);

    // Write then read same line, different byte offset, within one grant.
    d_access("wr0x200", 1'b1, 32'h0000_0200, AAA, rd);
    chk("wr0x200 d_data_held", d_mem_data_out, PRE);
    d_access("rd0x20C", 1'b0, 32'h0000_020C, '0, rd);
    chk("rd0x20C data", rd, AAA);

    // Done while BUSY is ignored.
    d_mem_op = 1'b0; d_mem_address = 32'h0000_0100; d_start_access = 1'b1;
    tick();
    d_start_access = 1'b0; d_mem_op_done = 1'b1;
    tick();
    d_mem_op_done = 1'b0;
    lat = 1;
    while (d_mem_data_ready !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    $display("done_busy lat=%0d data=%h", lat, d_mem_data_out);
    chk("done_busy latency", 128'(lat), 128'd5);
    chk("done_busy data", d_mem_data_out, PRE);
    tick();
    chk("done_busy allow_held", 128'(d_allow_op), 128'd1);

    // Contention from reset: last_grant=I so D wins, then alternation.
    reset = 1'b1; d_mem_op_init = 1'b0;
    tick();
    reset = 1'b0;
    i_mem_op_init = 1'b1; d_mem_op_init = 1'b1;
    tick();
    $display("contention grant i=%0d d=%0d", i_allow_op, d_allow_op);
    chk("cont1 d_allow", 128'(d_allow_op), 128'd1);
    chk("cont1 i_allow", 128'(i_allow_op), 128'd0);
    d_mem_op_done = 1'b1;
    tick();
    d_mem_op_done = 1'b0;
    chk("cont2 d_released", 128'(d_allow_op), 128'd0);
    chk("cont2 i_idle", 128'(i_allow_op), 128'd0);
    tick();
    chk("cont3 i_allow", 128'(i_allow_op), 128'd1);
    chk("cont3 d_allow", 128'(d_allow_op), 128'd0);
    i_access("i_rd0x200", 32'h0000_0200, rd);
    chk("i_rd0x200 data", rd, AAA);
    i_mem_op_done = 1'b1;
    tick();
    i_mem_op_done = 1'b0;
    chk("cont4 i_released", 128'(i_allow_op), 128'd0);
    tick();
    chk("cont5 d_allow", 128'(d_allow_op), 128'd1);
    chk("cont5 i_allow", 128'(i_allow_op), 128'd0);
    d_mem_op_done = 1'b1;
    tick();
    d_mem_op_done = 1'b0;
    tick();
    chk("cont6 i_allow", 128'(i_allow_op), 128'd1);
    i_mem_op_init = 1'b0;
    tick();
    chk("cont7 i_init_low", 128'(i_allow_op), 128'd0);
    tick();
    chk("cont8 d_allow", 128'(d_allow_op), 128'd1);

    // Reset two cycles into a write drops it.
    d_access("wr_old", 1'b1, 32'h0000_0300, OLD, rd);
    d_mem_op = 1'b1; d_mem_address = 32'h0000_0300; d_mem_data_in = NEW;
    d_start_access = 1'b1;
    tick();
    d_start_access = 1'b0;
    tick();
    reset = 1'b1; d_mem_op_init = 1'b0;
    tick();
    reset = 1'b0;
    $display("midwrite reset outputs i_allow=%0d d_allow=%0d d_data=%h", i_allow_op, d_allow_op, d_mem_data_out);
    chk("mrst d_allow", 128'(d_allow_op), 128'd0);
    chk("mrst i_allow", 128'(i_allow_op), 128'd0);
    chk("mrst d_ready", 128'(d_mem_data_ready), 128'd0);
    chk("mrst i_ready", 128'(i_mem_data_ready), 128'd0);
    chk("mrst d_data", d_mem_data_out, 128'd0);
    chk("mrst i_data", i_mem_data_out, 128'd0);
    d_mem_op_init = 1'b1;
    tick();
    chk("mrst regrant", 128'(d_allow_op), 128'd1);
    d_access("rd_old", 1'b0, 32'h0000_0300, '0, rd);
    chk("rd_old data", rd, OLD);

    // Index wrap: line 0x1000 aliases line 0.
    d_access("wr_wrap", 1'b1, 32'h0001_0000, WRP, rd);
    d_access("rd_zero", 1'b0, 32'h0000_0000, '0, rd);
    chk("rd_zero data", rd, WRP);
    d_access("rd_pre", 1'b0, 32'h0000_0100, '0, rd);
    chk("rd_pre data", rd, PRE);

    // Done together with start: release wins, no access starts.
    d_mem_op = 1'b1; d_mem_address = 32'h0000_0100; d_mem_data_in = NEW;
    d_start_access = 1'b1; d_mem_op_done = 1'b1; d_mem_op_init = 1'b0;
    tick();
    d_start_access = 1'b0; d_mem_op_done = 1'b0;
    chk("done_start released", 128'(d_allow_op), 128'd0);
    rcount = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (d_mem_data_ready === 1'b1) rcount++;
    end
    chk("done_start no_ready", 128'(rcount), 128'd0);
    chk("done_start data_held", d_mem_data_out, PRE);
    d_mem_op_init = 1'b1;
    tick();
    d_access("rd_pre2", 1'b0, 32'h0000_0100, '0, rd);
    chk("rd_pre2 no_write", rd, PRE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Responder end of the cache-to-memory handshake (mem_op_init / allow_op / start_access / mem_data_ready / mem_op_done).
- Arbitrates between the instruction cache (read-only client) and the data cache (read/write client).
- Owns a line-wide backing store with fixed access latency.
- Returns or stores whole cache lines.
- Exactly one client is granted at a time.

Parameters:
- MEM_LATENCY, 5, cycles from the accepted start_access to mem_data_ready; legal range is 1 or greater.
- MEM_DEPTH_LINES, 4096, number of 128-bit lines in the backing store; must be a power of two.
- ADDRESS_WIDTH, 32, byte address width.
- CACHE_LINE_SIZE, 128, line width in bits.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- i_mem_op_init  in  1  I-cache requests the bus.
- i_start_access  in  1  I-cache address valid; start the read.
- i_mem_op_done  in  1  I-cache releases the bus (one-cycle pulse).
- i_mem_address  in  ADDRESS_WIDTH  I-cache line address.
- i_allow_op  out  1  grant to the I-cache.
- i_mem_data_ready  out  1  I-cache read complete.
- i_mem_data_out  out  CACHE_LINE_SIZE  line returned to the I-cache.
- d_mem_op_init  in  1  D-cache requests the bus.
- d_start_access  in  1  D-cache address, op and data valid.
- d_mem_op_done  in  1  D-cache releases the bus.
- d_mem_op  in  1  0 = read, 1 = write (line writeback).
- d_mem_address  in  ADDRESS_WIDTH  D-cache line address.
- d_mem_data_in  in  CACHE_LINE_SIZE  line to write.
- d_allow_op  out  1  grant to the D-cache.
- d_mem_data_ready  out  1  D-cache access complete (read data valid or write committed).
- d_mem_data_out  out  CACHE_LINE_SIZE  line returned to the D-cache.

Behaviour:
- Reset (synchronous):
  - All outputs go to 0.
  - State goes to IDLE, the latency counter to 0, and last_grant to I.
  - Memory contents are not cleared.
  - Reset mid-access aborts the access; a write not yet committed is dropped.
- Line index: addr[ADDRESS_WIDTH-1:4], taken modulo MEM_DEPTH_LINES. Address bits [3:0] are ignored.
- IDLE:
  - If exactly one mem_op_init is high, grant that client.
  - If both are high, grant the client that is not last_grant (round-robin).
  - Move to GRANTED. The allow_op of the granted client is high from the next cycle.
  - allow_op stays high until release.
- GRANTED:
  - On start_access from the owning client, latch the line index, op and write data, and load the counter with MEM_LATENCY-1. Move to BUSY.
  - Requests from the non-owner are ignored; its mem_op_init stays pending.
  - The I-cache always reads, so i-side op is 0.
- BUSY:
  - Decrement the counter each cycle.
  - At 0, perform the access: a write stores the latched line; a read drives the line onto the owner's mem_data_out.
  - Pulse the owner's mem_data_ready for exactly one cycle, then move to GRANTED.
  - Timing: for MEM_LATENCY=N, ready is high in cycle N after the cycle where start_access was sampled.
  - mem_data_out holds its value until the next read completes for that client.
- Repeated accesses: the grant is kept after completion. The owner may issue further start_access cycles without re-arbitration; this covers the D-cache evict-then-fill sequence.
- Release: a mem_op_done pulse from the owner, or its mem_op_init low while GRANTED, clears allow_op next cycle, sets last_grant to that owner, and moves to IDLE.
  - A mem_op_done during BUSY is ignored.
- Owner drops start_access during BUSY: the access still completes.
- Simultaneous mem_op_done and start_access from the owner: mem_op_done wins and no access starts.
- Read-after-write to the same line returns the written data.
- The two allow_op outputs are never high together. Likewise the two mem_data_ready outputs.

Decomposition:
- parameters.v (shared package) gains:
  - the MEM_LATENCY default
  - MEM_DEPTH_LINES
  - state encodings ARB_IDLE=2'd0, ARB_GRANTED=2'd1, ARB_BUSY=2'd2
  - the client encodings CLIENT_I=1'b0, CLIENT_D=1'b1
- One sub-module, line_memory: a single-port synchronous RAM of CACHE_LINE_SIZE × MEM_DEPTH_LINES, with read data registered.
- The arbiter FSM and latency counter live in memory_arbiter.

Test Plan:
- Initialisation: preload line 0x10 = 0x0123...CDEF. D-cache runs init, start_access with addr 0x00000100, op=0, MEM_LATENCY=5. Required: d_allow_op=1 one cycle after init; d_mem_data_ready pulses 5 cycles after start_access with d_mem_data_out=preload; i-side outputs stay 0.
- Write then read: D-cache write of 0xAAAA...5555 to 0x00000200, then a read of 0x0000020C in the same grant. Required: the read returns 0xAAAA...5555; no re-grant cycle occurs between the two accesses.
- Contention: both clients raise init in the same cycle after reset (last_grant=I). Required: D granted first. After d_mem_op_done, I is granted 1 cycle after IDLE. With both requesting again, D and I alternate.
- Done during BUSY: D sends mem_op_done while BUSY. Required: it is ignored; ready still pulses and the grant is held.
- Reset mid-write: reset asserted 2 cycles after a D write start to 0x00000300. Required: all outputs are 0 next cycle and a later read of 0x00000300 returns the old contents.
- Address wrap: with MEM_DEPTH_LINES=4096, write to 0x00010000 then read 0x00000000. Required: the read returns the written line; index wraps to 0.
